execute_md: RTL and testbench
=============================

Name: execute_md

Overview:
- Parametrised successor to the single-cycle execute stage.
- Keeps the ALU path, the 3-way forwarding muxes, the branch/jump target adder and the control pass-through.
- Adds an iterative RV32M multiply/divide unit with a stall handshake, plus a flush input and instruction-valid qualification.
- Sits between the ID/EX and EX/MEM pipeline registers; the hazard unit consumes `stall_e`.

Parameters:
- DATA_WIDTH, 32, operand/result width; must be even and at least 8.
- ADDRESS_WIDTH, 32, PC width.
- CNT_W, $clog2(DATA_WIDTH)+1, iteration counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- flush_e  in  1  abort the in-flight mul/div and kill the current instruction.
- valid_d  in  1  instruction present in ID/EX.
- muldiv_d  in  1  instruction is an M-extension op; funct3_d selects the op.
- ctrl_d  in  reg_write(1), res_src(2), mem_write(1), jump(1), branch(1); pass-through controls.
- alu_control_d  in  6  ALU op.
- funct3_d  in  3  funct3 field.
- alu_src_a_d, alu_src_b_d, adder_src_d  in  1 each  source selects, same meaning as the current execute stage.
- rd1_d, rd2_d, imm_val_d  in  DATA_WIDTH  operands.
- pc_d, pc_plus4_d  in  ADDRESS_WIDTH  PCs.
- rd_d  in  5  destination register.
- alu_result_m, result_w  in  DATA_WIDTH  forwarding sources.
- forward_a_e, forward_b_e  in  2  forwarding select: 00 = reg, 01 = M, 10 = W, 11 = reg.
- ctrl_e  out  6  gated pass-through controls.
- funct3_e  out  3  pass-through funct3.
- rd_e  out  5  pass-through rd.
- pc_plus4_e  out  ADDRESS_WIDTH  pass-through PC+4.
- alu_result_e  out  DATA_WIDTH  ALU or mul/div result.
- write_data_e  out  DATA_WIDTH  forwarded rs2.
- pc_target_e  out  ADDRESS_WIDTH  branch/jump target.
- pc_src_e  out  1  redirect.
- stall_e  out  1  hold IF/ID/EX and insert a bubble into EX/MEM.
- busy_e  out  1  FSM not in IDLE.

Behaviour:
- Reset (synchronous, active-high):
  - State returns to IDLE; counter and operand registers clear.
  - `stall_e`, `busy_e` = 0.
  - Combinational outputs follow the inputs, with mul/div result = 0.
- Non-M path, identical to the current execute stage:
  - Forward muxes feed the A/B source muxes.
  - Target = (adder_src ? forwarded rs1 : pc) + imm.
  - pc_src_e = valid & (jump | branch & alu_res[0]).
  - Zero added latency.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE -> MUL/DIV when valid_d & muldiv_d & !flush_e. Forwarded operands latched that cycle; `stall_e` = 1 combinationally in that cycle.
  - MUL/DIV run DATA_WIDTH iterations (one bit per cycle), then go to DONE. `stall_e` = 1 throughout.
  - DONE: `stall_e` = 0; alu_result_e = latched result; ctrl_e passes through; next state IDLE, with no re-accept of the held instruction.
  - Total stall = DATA_WIDTH+1 cycles; instruction leaves EX DATA_WIDTH+1 cycles after acceptance.
- Multiply:
  - Shift-add on magnitudes into a 2W-bit product; sign fix-up at DONE entry.
  - MUL returns low W bits; MULH returns high (signed×signed); MULHSU returns high (signed×unsigned); MULHU returns high (unsigned).
- Divide:
  - Restoring, on magnitudes; sign fix-up: quotient negative if signs differ, remainder takes the dividend's sign.
  - Divide by zero: quotient = all ones, remainder = dividend. Goes IDLE -> DONE directly (1-cycle stall).
  - Signed overflow (MIN / −1): quotient = MIN, remainder = 0, also IDLE -> DONE directly.
- Gating while `stall_e` = 1: ctrl_e reg_write and mem_write forced to 0; pc_src_e forced to 0.
- flush_e in any state: next state IDLE, no result produced. Flush has priority over accept in the same cycle.
- If `rst` and `flush_e` are both asserted, `rst` wins.

Optional Feature:
- FAST_MUL_EN defined: multiply ops use a single combinational 2W-bit multiplier.
  - MUL* completes with no stall; div remains iterative.
  - Only DIV and DONE are reachable for div ops.
- Undefined: the iterative multiplier described above.

Decomposition:
- Package `exec_pkg`:
  - FSM state enum (2 bits).
  - funct3 constants MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7.
  - Forward-select constants.
- Sub-module `muldiv_iter`: FSM, counter, datapath, and special-case detection. Ports: start/op/a/b/flush → busy/done/result.
- The top level instantiates the existing mux3, mux2, adder and alu.

Test Plan:
- ADD, forward_a=01, alu_result_m=5, rd2=7 -> alu_result_e=12 same cycle; stall_e=0.
- MUL 0xFFFFFFFF×2, then MULHU of the same operands:
  - MUL: stall_e high 33 cycles, then alu_result_e=0xFFFFFFFE.
  - MULHU: result 0x00000001.
- DIV −7/2 -> 0xFFFFFFFD; REM −7/2 -> 0xFFFFFFFF; reg_write_e=0 during the stall.
- DIVU 9/0 -> 0xFFFFFFFF after a 1-cycle stall; DIV 0x80000000/−1 -> 0x80000000; REM of the same operands -> 0.
- flush_e at cycle 10 of a MUL -> next cycle busy_e=0 and stall_e=0; a following ADD executes normally.
- rst asserted mid-DIV -> next cycle state IDLE, busy_e=0; a BEQ taken -> pc_src_e=1, pc_target_e=pc+imm.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared types and constants for the execute stage with the iterative RV32M unit.
// Holds the mul/div FSM state type, funct3 op codes, forward selects and ALU op codes.
package exec_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } md_state_e;

    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    localparam logic [5:0] ALU_ADD  = 6'd0;
    localparam logic [5:0] ALU_SUB  = 6'd1;
    localparam logic [5:0] ALU_AND  = 6'd2;
    localparam logic [5:0] ALU_OR   = 6'd3;
    localparam logic [5:0] ALU_XOR  = 6'd4;
    localparam logic [5:0] ALU_SLT  = 6'd5;
    localparam logic [5:0] ALU_SLTU = 6'd6;
    localparam logic [5:0] ALU_SLL  = 6'd7;
    localparam logic [5:0] ALU_SRL  = 6'd8;
    localparam logic [5:0] ALU_SRA  = 6'd9;
    localparam logic [5:0] ALU_EQ   = 6'd10;
    localparam logic [5:0] ALU_NE   = 6'd11;
    localparam logic [5:0] ALU_LT   = 6'd12;
    localparam logic [5:0] ALU_GE   = 6'd13;
    localparam logic [5:0] ALU_LTU  = 6'd14;
    localparam logic [5:0] ALU_GEU  = 6'd15;

    // ctrl bundle layout: {reg_write, res_src[1:0], mem_write, jump, branch}
    localparam int CTRL_REG_WRITE = 5;
    localparam int CTRL_MEM_WRITE = 2;
    localparam int CTRL_JUMP      = 1;
    localparam int CTRL_BRANCH    = 0;

endpackage

// File: rtl/adder.sv
// Plain adder used for the branch/jump target.
module adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);
    assign y = a + b;
endmodule

// File: rtl/alu.sv
// Integer ALU; compare ops return their flag in bit 0 for branch resolution.
module alu
    import exec_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [5:0]            alu_control,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] result
);
    localparam int SH_W = $clog2(DATA_WIDTH);

    logic signed [DATA_WIDTH-1:0] a_s, b_s;
    logic        [SH_W-1:0]       shamt;

    assign a_s   = a;
    assign b_s   = b;
    assign shamt = b[SH_W-1:0];

    always_comb begin
        result = '0;
        case (alu_control)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_SLT:  result[0] = a_s < b_s;
            ALU_SLTU: result[0] = a < b;
            ALU_SLL:  result = a << shamt;
            ALU_SRL:  result = a >> shamt;
            ALU_SRA:  result = a_s >>> shamt;
            ALU_EQ:   result[0] = a == b;
            ALU_NE:   result[0] = a != b;
            ALU_LT:   result[0] = a_s < b_s;
            ALU_GE:   result[0] = a_s >= b_s;
            ALU_LTU:  result[0] = a < b;
            ALU_GEU:  result[0] = a >= b;
            default:  result = '0;
        endcase
    end
endmodule

// File: rtl/muldiv_iter.sv
// Iterative RV32M unit: shift-add multiply and restoring divide, one bit per cycle.
// FAST_MUL_EN: multiplies use a single combinational multiplier; only divides iterate.
module muldiv_iter
    import exec_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_W      = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  flush,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  busy,
    output logic                  done,
    output logic                  stall,
    output logic [DATA_WIDTH-1:0] result
);
    localparam int W = DATA_WIDTH;
    localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

    md_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [2*W-1:0]   acc_q;
    logic [W-1:0]     opa_q, opb_q, res_q;
    logic [2:0]       op_q;
    logic             neg_q, rneg_q;

    logic         is_div, a_signed, b_signed, a_neg, b_neg;
    logic         div_zero, div_ovf, accept, last;
    logic [W-1:0] a_mag, b_mag, sp_res;

    assign is_div   = op[2];
    assign a_signed = (op != F3_MULHU) && (op != F3_DIVU) && (op != F3_REMU);
    assign b_signed = (op == F3_MUL) || (op == F3_MULH) || (op == F3_DIV) || (op == F3_REM);
    assign a_neg    = a_signed & a[W-1];
    assign b_neg    = b_signed & b[W-1];
    assign a_mag    = a_neg ? -a : a;
    assign b_mag    = b_neg ? -b : b;
    assign div_zero = (b == '0);
    assign div_ovf  = ((op == F3_DIV) || (op == F3_REM)) && (a == MIN_VAL) && (b == '1);
    assign last     = (cnt_q == CNT_W'(W - 1));

`ifdef FAST_MUL_EN
    assign accept = start & ~flush & (state_q == ST_IDLE) & is_div;
`else
    assign accept = start & ~flush & (state_q == ST_IDLE);
`endif

    // Divide special cases resolve at acceptance and skip the iterations.
    always_comb begin
        if (div_zero) sp_res = op[1] ? a : '1;
        else          sp_res = op[1] ? '0 : MIN_VAL;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = !is_div ? ST_MUL :
                                           (div_zero || div_ovf) ? ST_DONE : ST_DIV;
            ST_MUL,
            ST_DIV:  if (last) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (flush) state_d = ST_IDLE;
    end

    logic [W:0]     mul_sum, rem_sh;
    logic [2*W-1:0] mul_next, prod_fix;
    logic [W-1:0]   mul_res, div_diff, new_rem, new_quot, quot_fix, rem_fix, div_res;
    logic           ge;

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*W-1:W]} + (opb_q[0] ? {1'b0, opa_q} : {(W+1){1'b0}});
        mul_next = {mul_sum, acc_q[W-1:1]};
        prod_fix = neg_q ? -mul_next : mul_next;
        mul_res  = (op_q == F3_MUL) ? prod_fix[W-1:0] : prod_fix[2*W-1:W];

        rem_sh   = {acc_q[W-1:0], opb_q[W-1]};
        ge       = rem_sh >= {1'b0, opa_q};
        div_diff = rem_sh[W-1:0] - opa_q;
        new_rem  = ge ? div_diff : rem_sh[W-1:0];
        new_quot = {opb_q[W-2:0], ge};
        quot_fix = neg_q  ? -new_quot : new_quot;
        rem_fix  = rneg_q ? -new_rem  : new_rem;
        div_res  = op_q[1] ? rem_fix : quot_fix;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            op_q    <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: if (accept) begin
                    op_q   <= op;
                    cnt_q  <= '0;
                    acc_q  <= '0;
                    opa_q  <= is_div ? b_mag : a_mag;
                    opb_q  <= is_div ? a_mag : b_mag;
                    neg_q  <= a_neg ^ b_neg;
                    rneg_q <= a_neg;
                    res_q  <= sp_res;
                end
                ST_MUL: begin
                    acc_q <= mul_next;
                    opb_q <= opb_q >> 1;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (last) res_q <= mul_res;
                end
                ST_DIV: begin
                    acc_q <= {{W{1'b0}}, new_rem};
                    opb_q <= new_quot;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (last) res_q <= div_res;
                end
                default: ;
            endcase
        end
    end

    assign busy  = (state_q != ST_IDLE);
    assign done  = (state_q == ST_DONE);
    assign stall = accept | (state_q == ST_MUL) | (state_q == ST_DIV);

`ifdef FAST_MUL_EN
    logic signed [W:0]     fa_s, fb_s;
    logic signed [2*W+1:0] fprod;
    assign fa_s  = {a_signed & a[W-1], a};
    assign fb_s  = {b_signed & b[W-1], b};
    assign fprod = fa_s * fb_s;
    always_comb begin
        result = '0;
        if (state_q == ST_DONE)              result = res_q;
        else if (start && !is_div && !flush) result = (op == F3_MUL) ? fprod[W-1:0] : fprod[2*W-1:W];
    end
`else
    assign result = (state_q == ST_DONE) ? res_q : '0;
`endif

endmodule

// File: rtl/mux2.sv
// Two-input mux.
module mux2 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic             s,
    output logic [WIDTH-1:0] y
);
    assign y = s ? d1 : d0;
endmodule

// File: rtl/mux3.sv
// Three-way forwarding mux; select 11 falls back to the register value.
module mux3
    import exec_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [1:0]       s,
    output logic [WIDTH-1:0] y
);
    always_comb begin
        case (s)
            FWD_MEM: y = d1;
            FWD_WB:  y = d2;
            default: y = d0;
        endcase
    end
endmodule

// File: rtl/execute_md.sv
// Execute stage: forwarding, ALU, branch target and an iterative RV32M unit with stall.
// Optional FAST_MUL_EN selects a single-cycle multiplier inside muldiv_iter.
module execute_md
    import exec_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int CNT_W         = $clog2(DATA_WIDTH) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_e,
    input  logic                     valid_d,
    input  logic                     muldiv_d,
    input  logic [5:0]               ctrl_d,
    input  logic [5:0]               alu_control_d,
    input  logic [2:0]               funct3_d,
    input  logic                     alu_src_a_d,
    input  logic                     alu_src_b_d,
    input  logic                     adder_src_d,
    input  logic [DATA_WIDTH-1:0]    rd1_d,
    input  logic [DATA_WIDTH-1:0]    rd2_d,
    input  logic [DATA_WIDTH-1:0]    imm_val_d,
    input  logic [ADDRESS_WIDTH-1:0] pc_d,
    input  logic [ADDRESS_WIDTH-1:0] pc_plus4_d,
    input  logic [4:0]               rd_d,
    input  logic [DATA_WIDTH-1:0]    alu_result_m,
    input  logic [DATA_WIDTH-1:0]    result_w,
    input  logic [1:0]               forward_a_e,
    input  logic [1:0]               forward_b_e,
    output logic [5:0]               ctrl_e,
    output logic [2:0]               funct3_e,
    output logic [4:0]               rd_e,
    output logic [ADDRESS_WIDTH-1:0] pc_plus4_e,
    output logic [DATA_WIDTH-1:0]    alu_result_e,
    output logic [DATA_WIDTH-1:0]    write_data_e,
    output logic [ADDRESS_WIDTH-1:0] pc_target_e,
    output logic                     pc_src_e,
    output logic                     stall_e,
    output logic                     busy_e
);
    logic [DATA_WIDTH-1:0]    fwd_a, fwd_b, src_a, src_b, alu_res, md_result;
    logic [ADDRESS_WIDTH-1:0] tgt_base;
    logic                     kill_wr;

    mux3 #(.WIDTH(DATA_WIDTH)) u_fwd_a (
        .d0(rd1_d), .d1(alu_result_m), .d2(result_w), .s(forward_a_e), .y(fwd_a));
    mux3 #(.WIDTH(DATA_WIDTH)) u_fwd_b (
        .d0(rd2_d), .d1(alu_result_m), .d2(result_w), .s(forward_b_e), .y(fwd_b));

    mux2 #(.WIDTH(DATA_WIDTH)) u_src_a (
        .d0(fwd_a), .d1(DATA_WIDTH'(pc_d)), .s(alu_src_a_d), .y(src_a));
    mux2 #(.WIDTH(DATA_WIDTH)) u_src_b (
        .d0(fwd_b), .d1(imm_val_d), .s(alu_src_b_d), .y(src_b));

    alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
        .alu_control(alu_control_d), .a(src_a), .b(src_b), .result(alu_res));

    mux2 #(.WIDTH(ADDRESS_WIDTH)) u_tgt_base (
        .d0(pc_d), .d1(ADDRESS_WIDTH'(fwd_a)), .s(adder_src_d), .y(tgt_base));
    adder #(.WIDTH(ADDRESS_WIDTH)) u_tgt (
        .a(tgt_base), .b(ADDRESS_WIDTH'(imm_val_d)), .y(pc_target_e));

    // The M unit always sees the forwarded registers, never the immediate or PC.
    muldiv_iter #(.DATA_WIDTH(DATA_WIDTH), .CNT_W(CNT_W)) u_md (
        .clk(clk), .rst(rst), .start(valid_d & muldiv_d), .flush(flush_e),
        .op(funct3_d), .a(fwd_a), .b(fwd_b),
        .busy(busy_e), .done(), .stall(stall_e), .result(md_result));

    assign kill_wr = ~valid_d | flush_e | stall_e;

    assign ctrl_e = {ctrl_d[CTRL_REG_WRITE] & ~kill_wr,
                     ctrl_d[4:3],
                     ctrl_d[CTRL_MEM_WRITE] & ~kill_wr,
                     ctrl_d[CTRL_JUMP],
                     ctrl_d[CTRL_BRANCH]};

    assign pc_src_e     = valid_d & ~stall_e &
                          (ctrl_d[CTRL_JUMP] | (ctrl_d[CTRL_BRANCH] & alu_res[0]));
    assign alu_result_e = muldiv_d ? md_result : alu_res;
    assign write_data_e = fwd_b;
    assign funct3_e     = funct3_d;
    assign rd_e         = rd_d;
    assign pc_plus4_e   = pc_plus4_d;

endmodule

// File: tb/tb_execute_md.sv
// Scoreboard bench for execute_md: directed instructions with hand-computed results.
module tb_execute_md;
    import exec_pkg::*;

    logic        clk, rst, flush_e, valid_d, muldiv_d;
    logic [5:0]  ctrl_d, alu_control_d;
    logic [2:0]  funct3_d;
    logic        alu_src_a_d, alu_src_b_d, adder_src_d;
    logic [31:0] rd1_d, rd2_d, imm_val_d, pc_d, pc_plus4_d;
    logic [4:0]  rd_d;
    logic [31:0] alu_result_m, result_w;
    logic [1:0]  forward_a_e, forward_b_e;
    logic [5:0]  ctrl_e;
    logic [2:0]  funct3_e;
    logic [4:0]  rd_e;
    logic [31:0] pc_plus4_e, alu_result_e, write_data_e, pc_target_e;
    logic        pc_src_e, stall_e, busy_e;

    execute_md dut (
        .clk(clk), .rst(rst), .flush_e(flush_e), .valid_d(valid_d), .muldiv_d(muldiv_d),
        .ctrl_d(ctrl_d), .alu_control_d(alu_control_d), .funct3_d(funct3_d),
        .alu_src_a_d(alu_src_a_d), .alu_src_b_d(alu_src_b_d), .adder_src_d(adder_src_d),
        .rd1_d(rd1_d), .rd2_d(rd2_d), .imm_val_d(imm_val_d), .pc_d(pc_d),
        .pc_plus4_d(pc_plus4_d), .rd_d(rd_d), .alu_result_m(alu_result_m),
        .result_w(result_w), .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
        .ctrl_e(ctrl_e), .funct3_e(funct3_e), .rd_e(rd_e), .pc_plus4_e(pc_plus4_e),
        .alu_result_e(alu_result_e), .write_data_e(write_data_e),
        .pc_target_e(pc_target_e), .pc_src_e(pc_src_e), .stall_e(stall_e), .busy_e(busy_e));

    typedef struct {
        string       nm;
        logic [31:0] res;
        logic        rw;
        logic        pcsrc;
        logic [31:0] tgt;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;

    localparam logic [5:0] CTRL_RW  = 6'b100000;
    localparam logic [5:0] CTRL_BEQ = 6'b000001;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    // Monitor: an instruction leaves EX whenever it is valid, not flushed and not stalled.
    always @(negedge clk) begin
        if (!rst && valid_d && !flush_e && !stall_e) begin
            if (expq.size() == 0) begin
                chk("unexpected_output", {32'h0, alu_result_e}, 64'hDEAD_BEEF_DEAD_BEEF);
            end else begin
                exp_t e;
                e = expq.pop_front();
                chk({e.nm, "_result"}, {32'h0, alu_result_e}, {32'h0, e.res});
                chk({e.nm, "_reg_write"}, {63'h0, ctrl_e[5]}, {63'h0, e.rw});
                chk({e.nm, "_pc_src"}, {63'h0, pc_src_e}, {63'h0, e.pcsrc});
                chk({e.nm, "_target"}, {32'h0, pc_target_e}, {32'h0, e.tgt});
            end
        end
    end

    task automatic drive(input logic md, input logic [2:0] f3, input logic [5:0] aluc,
                         input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] imm,
                         input logic [1:0] fa, input logic [5:0] ctrl);
        valid_d       = 1'b1;
        muldiv_d      = md;
        funct3_d      = f3;
        alu_control_d = aluc;
        rd1_d         = r1;
        rd2_d         = r2;
        imm_val_d     = imm;
        forward_a_e   = fa;
        forward_b_e   = FWD_REG;
        ctrl_d        = ctrl;
    endtask

    // Called just after a rising edge; returns just after the edge that retires the instruction.
    task automatic run(input string nm, input logic md, input logic [2:0] f3,
                       input logic [5:0] aluc, input logic [31:0] r1, input logic [31:0] r2,
                       input logic [31:0] imm, input logic [1:0] fa, input logic [5:0] ctrl,
                       input logic [31:0] res, input logic pcsrc, input int exp_stall);
        exp_t e;
        int   stalls;
        logic rw_hi;
        e.nm = nm; e.res = res; e.rw = ctrl[5]; e.pcsrc = pcsrc; e.tgt = 32'h100 + imm;
        expq.push_back(e);
        drive(md, f3, aluc, r1, r2, imm, fa, ctrl);
        stalls = 0;
        rw_hi  = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!stall_e) break;
            stalls++;
            if (ctrl_e[5] || pc_src_e) rw_hi = 1'b1;
        end
        chk({nm, "_stall_cycles"}, 64'(stalls), 64'(exp_stall));
        if (stalls > 0) chk({nm, "_gated_in_stall"}, {63'h0, rw_hi}, 64'h0);
        @(posedge clk);
        #1;
        valid_d = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush_e = 1'b0; valid_d = 1'b0; muldiv_d = 1'b0;
        ctrl_d = '0; alu_control_d = ALU_ADD; funct3_d = '0;
        alu_src_a_d = 1'b0; alu_src_b_d = 1'b0; adder_src_d = 1'b0;
        rd1_d = '0; rd2_d = '0; imm_val_d = '0; pc_d = 32'h100; pc_plus4_d = 32'h104;
        rd_d = 5'd3; alu_result_m = 32'd5; result_w = 32'h33;
        forward_a_e = FWD_REG; forward_b_e = FWD_REG;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", {63'h0, busy_e}, 64'h0);
        chk("reset_stall", {63'h0, stall_e}, 64'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        run("add_fwd_m", 1'b0, 3'd0, ALU_ADD, 32'd99, 32'd7, 32'h0, FWD_MEM, CTRL_RW,
            32'd12, 1'b0, 0);
        run("mul", 1'b1, F3_MUL, ALU_ADD, 32'hFFFF_FFFF, 32'd2, 32'h0, FWD_REG, CTRL_RW,
            32'hFFFF_FFFE, 1'b0, 33);
        run("mulhu", 1'b1, F3_MULHU, ALU_ADD, 32'hFFFF_FFFF, 32'd2, 32'h0, FWD_REG, CTRL_RW,
            32'h0000_0001, 1'b0, 33);
        run("mulh", 1'b1, F3_MULH, ALU_ADD, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0, FWD_REG,
            CTRL_RW, 32'h3FFF_FFFF, 1'b0, 33);
        run("mulhsu", 1'b1, F3_MULHSU, ALU_ADD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, FWD_REG,
            CTRL_RW, 32'hFFFF_FFFF, 1'b0, 33);
        run("div_neg", 1'b1, F3_DIV, ALU_ADD, 32'hFFFF_FFF9, 32'd2, 32'h0, FWD_REG, CTRL_RW,
            32'hFFFF_FFFD, 1'b0, 33);
        run("rem_neg", 1'b1, F3_REM, ALU_ADD, 32'hFFFF_FFF9, 32'd2, 32'h0, FWD_REG, CTRL_RW,
            32'hFFFF_FFFF, 1'b0, 33);
        run("divu", 1'b1, F3_DIVU, ALU_ADD, 32'd100, 32'd7, 32'h0, FWD_REG, CTRL_RW,
            32'd14, 1'b0, 33);
        run("remu", 1'b1, F3_REMU, ALU_ADD, 32'd100, 32'd7, 32'h0, FWD_REG, CTRL_RW,
            32'd2, 1'b0, 33);
        run("divu_by0", 1'b1, F3_DIVU, ALU_ADD, 32'd9, 32'd0, 32'h0, FWD_REG, CTRL_RW,
            32'hFFFF_FFFF, 1'b0, 1);
        run("remu_by0", 1'b1, F3_REMU, ALU_ADD, 32'd9, 32'd0, 32'h0, FWD_REG, CTRL_RW,
            32'd9, 1'b0, 1);
        run("div_ovf", 1'b1, F3_DIV, ALU_ADD, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, FWD_REG,
            CTRL_RW, 32'h8000_0000, 1'b0, 1);
        run("rem_ovf", 1'b1, F3_REM, ALU_ADD, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, FWD_REG,
            CTRL_RW, 32'h0, 1'b0, 1);

        // Flush on the tenth cycle of a multiply: nothing retires, the unit goes idle.
        drive(1'b1, F3_MUL, ALU_ADD, 32'd3, 32'd4, 32'h0, FWD_REG, CTRL_RW);
        repeat (9) @(posedge clk);
        #1 flush_e = 1'b1;
        @(posedge clk);
        #1 flush_e = 1'b0;
        valid_d = 1'b0;
        @(negedge clk);
        chk("flush_busy", {63'h0, busy_e}, 64'h0);
        chk("flush_stall", {63'h0, stall_e}, 64'h0);
        @(posedge clk);
        #1;
        run("add_after_flush", 1'b0, 3'd0, ALU_ADD, 32'd3, 32'd4, 32'h0, FWD_REG, CTRL_RW,
            32'd7, 1'b0, 0);

        // Reset in the middle of a divide.
        drive(1'b1, F3_DIV, ALU_ADD, 32'd1000, 32'd3, 32'h0, FWD_REG, CTRL_RW);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        valid_d = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_div_busy", {63'h0, busy_e}, 64'h0);
        chk("rst_mid_div_stall", {63'h0, stall_e}, 64'h0);
        @(posedge clk);
        #1;
        run("beq_taken", 1'b0, 3'd0, ALU_EQ, 32'd10, 32'd10, 32'h20, FWD_REG, CTRL_BEQ,
            32'd1, 1'b1, 0);
        run("beq_not_taken", 1'b0, 3'd0, ALU_EQ, 32'd10, 32'd11, 32'h40, FWD_REG, CTRL_BEQ,
            32'd0, 1'b0, 0);

        for (int i = 0; i < 20 && expq.size() != 0; i++) @(negedge clk);
        chk("queue_drained", 64'(expq.size()), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
